render_frame_sched: RTL and testbench

- Per-frame sequencer for the ppl -> map -> align render datapath.
- Snapshots player pose so the pose stays constant for a whole frame, and pulses the frame start.
- Counts aligned output pixels to detect frame completion.
- Swaps the double-buffered frame store on display vsync and flags timeout and overrun errors.
- Sits between the player/control logic, the ppl pipeline and the frame-buffer bank selects, all in the PPL_clk domain.

---
 rtl/render_frame_sched.sv | 112 +++++++++++
 tb/tb_render_frame_sched.sv | 139 +++++++++++++
 2 files changed

// File: rtl/render_frame_sched.sv
// render_frame_sched: per-frame sequencer that latches a stable pose, counts rendered pixels
// and swaps the double-buffered frame store on vsync.
module render_frame_sched #(
    parameter int          H_DISP  = 480,
    parameter int          V_DISP  = 272,
    parameter logic [23:0] TIMEOUT = 24'd4000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        vsync,
    input  logic        pose_valid,
    input  logic [16:0] pos_x_in,
    input  logic [16:0] pos_y_in,
    input  logic [16:0] pos_z_in,
    input  logic [15:0] angle_x_in,
    input  logic [15:0] angle_y_in,
    input  logic        pix_valid,
    output logic [16:0] p_pos_x,
    output logic [16:0] p_pos_y,
    output logic [16:0] p_pos_z,
    output logic [15:0] p_angle_x,
    output logic [15:0] p_angle_y,
    output logic        render_start,
    output logic        busy,
    output logic        frame_done,
    output logic        wr_bank,
    output logic        disp_bank,
    output logic [15:0] frame_cnt,
    output logic        err_timeout,
    output logic        err_overrun
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RENDER    = 2'd1;
    localparam logic [1:0] SWAP_WAIT = 2'd2;
    localparam logic [19:0] LAST_PIX = 20'(H_DISP * V_DISP - 1);

    logic [1:0]  state;
    logic        vsync_d, completed;
    logic [19:0] pix_cnt;
    logic [23:0] to_cnt;
    logic [16:0] sh_x, sh_y, sh_z;
    logic [15:0] sh_ax, sh_ay;
    logic        vs_rise, start;

    assign vs_rise   = vsync & ~vsync_d;
    assign start     = vs_rise & enable & (state == IDLE || state == SWAP_WAIT);
    assign busy      = state == RENDER;
    assign disp_bank = ~wr_bank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vsync_d      <= 1'b0;
            completed    <= 1'b0;
            pix_cnt      <= '0;
            to_cnt       <= '0;
            {sh_x, sh_y, sh_z, sh_ax, sh_ay} <= '0;
            {p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y} <= '0;
            render_start <= 1'b0;
            frame_done   <= 1'b0;
            wr_bank      <= 1'b0;
            frame_cnt    <= '0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            vsync_d      <= vsync;
            render_start <= 1'b0;
            frame_done   <= 1'b0;
            if (pose_valid)
                {sh_x, sh_y, sh_z, sh_ax, sh_ay} <= {pos_x_in, pos_y_in, pos_z_in, angle_x_in, angle_y_in};
            case (state)
                RENDER: begin
                    to_cnt <= to_cnt + 24'd1;
                    if (pix_valid)
                        pix_cnt <= pix_cnt + 20'd1;
                    if (pix_valid && pix_cnt == LAST_PIX) begin
                        frame_done <= 1'b1;
                        completed  <= 1'b1;
                        state      <= SWAP_WAIT;
                    end else if (to_cnt == TIMEOUT - 24'd1) begin
                        err_timeout <= 1'b1;
                        completed   <= 1'b0;
                        state       <= SWAP_WAIT;
                    end
                end
                SWAP_WAIT: begin
                    if (pix_valid)
                        err_overrun <= 1'b1;
                    if (vs_rise) begin
                        if (completed) begin
                            wr_bank   <= ~wr_bank;
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // a start overrides the state chosen above, giving back-to-back frames out of SWAP_WAIT
            if (start) begin
                {p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y} <= pose_valid ?
                    {pos_x_in, pos_y_in, pos_z_in, angle_x_in, angle_y_in} :
                    {sh_x, sh_y, sh_z, sh_ax, sh_ay};
                render_start <= 1'b1;
                pix_cnt      <= '0;
                to_cnt       <= '0;
                state        <= RENDER;
            end
        end
    end
endmodule

// File: tb/tb_render_frame_sched.sv
// tb_render_frame_sched: directed checks of frame start, completion, swap, timeout and overrun.
module tb_render_frame_sched;
    logic        clk = 1'b0;
    logic        rst_n, enable, vsync, pose_valid, pix_valid;
    logic [16:0] pos_x_in, pos_y_in, pos_z_in;
    logic [15:0] angle_x_in, angle_y_in;
    logic [16:0] p_pos_x, p_pos_y, p_pos_z;
    logic [15:0] p_angle_x, p_angle_y;
    logic        render_start, busy, frame_done, wr_bank, disp_bank, err_timeout, err_overrun;
    logic [15:0] frame_cnt;
    int          n_vec = 0, n_err = 0;

    render_frame_sched #(.H_DISP(16), .V_DISP(12), .TIMEOUT(24'd300)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync), .pose_valid(pose_valid),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .pos_z_in(pos_z_in),
        .angle_x_in(angle_x_in), .angle_y_in(angle_y_in), .pix_valid(pix_valid),
        .p_pos_x(p_pos_x), .p_pos_y(p_pos_y), .p_pos_z(p_pos_z),
        .p_angle_x(p_angle_x), .p_angle_y(p_angle_y), .render_start(render_start),
        .busy(busy), .frame_done(frame_done), .wr_bank(wr_bank), .disp_bank(disp_bank),
        .frame_cnt(frame_cnt), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " wr_bank"}, 32'(wr_bank), 0);
        chk({tag, " disp_bank"}, 32'(disp_bank), 1);
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " render_start"}, 32'(render_start), 0);
        chk({tag, " err_timeout"}, 32'(err_timeout), 0);
        chk({tag, " err_overrun"}, 32'(err_overrun), 0);
        chk({tag, " p_pos_x"}, 32'(p_pos_x), 0);
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            step();
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; pose_valid = 1'b0; pix_valid = 1'b0;
        pos_x_in = '0; pos_y_in = '0; pos_z_in = '0; angle_x_in = '0; angle_y_in = '0;
        step(); step();
        check_reset("reset");
        rst_n = 1'b1; enable = 1'b1;
        repeat (8) step();
        // first frame start from IDLE
        vsync = 1'b1; step();
        chk("start1 render_start", 32'(render_start), 1);
        chk("start1 busy", 32'(busy), 1);
        chk("start1 p_pos_x", 32'(p_pos_x), 0);
        vsync = 1'b0; step();
        chk("start1 pulse width", 32'(render_start), 0);
        pos_x_in = 17'(33 << 10); pose_valid = 1'b1; step(); pose_valid = 1'b0;
        chk("pose held in RENDER", 32'(p_pos_x), 0);
        vsync = 1'b1; step(); vsync = 1'b0; step();
        chk("vsync in RENDER no restart", 32'(render_start), 0);
        chk("vsync in RENDER busy", 32'(busy), 1);
        chk("vsync in RENDER no swap", 32'(frame_cnt), 0);
        pixels(191);
        chk("frame_done before last", 32'(frame_done), 0);
        pixels(1);
        chk("frame_done on last", 32'(frame_done), 1);
        chk("busy after last", 32'(busy), 0);
        step();
        chk("frame_done one cycle", 32'(frame_done), 0);
        chk("no swap before vsync", 32'(wr_bank), 0);
        // swap with back-to-back restart
        vsync = 1'b1; step();
        chk("swap wr_bank", 32'(wr_bank), 1);
        chk("swap disp_bank", 32'(disp_bank), 0);
        chk("swap frame_cnt", 32'(frame_cnt), 1);
        chk("restart render_start", 32'(render_start), 1);
        chk("shadow applied", 32'(p_pos_x), 33 << 10);
        vsync = 1'b0;
        // timeout frame: 5 pixels then nothing
        for (int i = 0; i < 299; i++) begin
            pix_valid = (i < 5);
            step();
        end
        pix_valid = 1'b0;
        chk("pre-timeout busy", 32'(busy), 1);
        chk("pre-timeout err", 32'(err_timeout), 0);
        step();
        chk("timeout busy", 32'(busy), 0);
        chk("timeout err", 32'(err_timeout), 1);
        chk("timeout no frame_done", 32'(frame_done), 0);
        pixels(1);
        chk("overrun set", 32'(err_overrun), 1);
        step();
        chk("overrun sticky", 32'(err_overrun), 1);
        // aborted frame: no swap; pose bypass on start cycle
        vsync = 1'b1; pose_valid = 1'b1; pos_x_in = 17'd77; step();
        vsync = 1'b0; pose_valid = 1'b0;
        chk("abort no toggle", 32'(wr_bank), 1);
        chk("abort no count", 32'(frame_cnt), 1);
        chk("abort restart", 32'(render_start), 1);
        chk("bypass pose", 32'(p_pos_x), 77);
        // enable dropped mid-frame
        enable = 1'b0;
        pixels(192);
        chk("noenable frame_done", 32'(frame_done), 1);
        vsync = 1'b1; step(); vsync = 1'b0;
        chk("noenable swap", 32'(wr_bank), 0);
        chk("noenable count", 32'(frame_cnt), 2);
        chk("noenable no start", 32'(render_start), 0);
        chk("noenable idle", 32'(busy), 0);
        step();
        vsync = 1'b1; step(); vsync = 1'b0; step();
        chk("idle stays idle", 32'(busy), 0);
        chk("err_timeout sticky", 32'(err_timeout), 1);
        // async reset mid-RENDER
        enable = 1'b1;
        vsync = 1'b1; step(); vsync = 1'b0;
        chk("restart busy", 32'(busy), 1);
        pixels(3);
        #2 rst_n = 1'b0;
        #1 check_reset("async reset");
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
